// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the two-port async SRAM arbiter/sequencer.
package sram_arb_pkg;

    localparam int NPORTS      = 2;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, RD, WR, TURN} sram_state_t;

    // Request fields latched at grant; sized for the board's 1M x 16 part.
    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } sram_req_t;

endpackage

// File: rtl/sram_arbiter_ctrl_rr_arbiter2.sv
// Two-port round-robin arbiter: combinational grant, last-winner memory updated
// only when both ports contend, so a lone requester never disturbs the fairness order.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req_i,
    input  logic              advance_i,
    output logic [NPORTS-1:0] gnt_o,
    output logic              gnt_id_o
);

    logic rr_last_q;

    always_comb begin
        gnt_id_o = 1'b0;
        if (&req_i) begin
            gnt_id_o = ~rr_last_q;
        end else if (req_i[1]) begin
            gnt_id_o = 1'b1;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else if (advance_i && (&req_i)) begin
            rr_last_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Two-port arbiter and access sequencer for the board's async 16-bit SRAM.
// Every pin-side control is a flop decoded from the next state, so the pins never glitch.
module sram_arbiter_ctrl
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPORTS-1:0]              req_i,
    input  logic [NPORTS-1:0]              we_i,
    input  logic [NPORTS-1:0][ADDR_W-1:0]  addr_i,
    input  logic [NPORTS-1:0][DATA_W-1:0]  wdata_i,
    input  logic [NPORTS-1:0][1:0]         be_i,
    output logic [NPORTS-1:0]              ack_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           busy_o,
    output logic [ADDR_W-1:0]              sram_addr_o,
    input  logic [DATA_W-1:0]              sram_dq_i,
    output logic [DATA_W-1:0]              sram_dq_o,
    output logic                           sram_dq_oe_o,
    output logic                           sram_ce_n_o,
    output logic                           sram_oe_n_o,
    output logic                           sram_we_n_o,
    output logic                           sram_lb_n_o,
    output logic                           sram_ub_n_o
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    sram_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    sram_req_t         req_q, req_d;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [NPORTS-1:0] arb_gnt;
    logic              arb_gnt_id;
    logic              grant;

    logic              ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q, dq_oe_q;
    logic              ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d;
    logic [NPORTS-1:0] ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .advance_i (grant),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_gnt_id)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        gnt_d   = gnt_q;
        grant   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant       = 1'b1;
                    gnt_d       = arb_gnt;
                    req_d.we    = we_i[arb_gnt_id];
                    req_d.addr  = addr_i[arb_gnt_id];
                    req_d.wdata = wdata_i[arb_gnt_id];
                    req_d.be    = be_i[arb_gnt_id];
                    cnt_d       = '0;
                    state_d     = we_i[arb_gnt_id] ? WR : RD;
                end
            end
            RD: begin
                if (cnt_q == RD_LAST) state_d = TURN;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            WR: begin
                if (cnt_q == WR_LAST) state_d = TURN;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ack_d   = '0;

        unique case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                lb_n_d = ~req_d.be[0];
                ub_n_d = ~req_d.be[1];
            end
            WR: begin
                // WE rises for the last cycle so data stays driven past the rising edge.
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                we_n_d  = (cnt_d == WR_LAST);
                lb_n_d  = ~req_d.be[0];
                ub_n_d  = ~req_d.be[1];
            end
            TURN:    ack_d = gnt_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            gnt_q   <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
            dq_oe_q <= dq_oe_d;
            ack_q   <= ack_d;
            if (state_q == RD && cnt_q == RD_LAST) begin
                rdata_q <= sram_dq_i;
            end
        end
    end

    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign sram_addr_o  = req_q.addr;
    assign sram_dq_o    = req_q.wdata;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_lb_n_o  = lb_n_q;
    assign sram_ub_n_o  = ub_n_q;

endmodule
